// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - branch/jump next-PC resolution with registered valid/ready result
// Optional statistics counters: define BRANCH_RESOLVE_STAT_EN.
module branch_resolve #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [1:0]      op_i,
    input  logic            cmp_taken_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic            taken_o,
    output logic [XLEN-1:0] next_pc_o,
    output logic [XLEN-1:0] link_o,
    output logic            misalign_o
`ifdef BRANCH_RESOLVE_STAT_EN
    ,
    output logic [31:0]     stat_branches_o,
    output logic [31:0]     stat_taken_o,
    output logic [31:0]     stat_jumps_o
`endif
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    localparam logic [1:0] OP_BR   = 2'b00;
    localparam logic [1:0] OP_JAL  = 2'b01;
    localparam logic [1:0] OP_JALR = 2'b10;

    state_t          state;
    state_t          state_next;
    logic            accept;
    logic            res_taken;
    logic [XLEN-1:0] res_target;
    logic [XLEN-1:0] res_link;
    logic [XLEN-1:0] res_next_pc;
    logic            res_misalign;

    assign out_valid_o = (state == HOLD);
    assign accept      = in_valid_i & in_ready_o;

    always_comb begin
        in_ready_o = ~rst & ((state == IDLE) | (out_valid_o & out_ready_i & ~flush_i));
        state_next = state;
        if (state == HOLD && flush_i) begin
            state_next = IDLE;
        end else if (accept) begin
            state_next = HOLD;
        end else if (state == HOLD && out_ready_i) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        res_taken  = 1'b0;
        res_target = pc_i + imm_i;
        res_link   = pc_i + XLEN'(4);
        case (op_i)
            OP_BR:   res_taken = cmp_taken_i;
            OP_JAL:  res_taken = 1'b1;
            OP_JALR: begin
                res_taken  = 1'b1;
                res_target = (rs1_i + imm_i) & {{(XLEN-1){1'b1}}, 1'b0};
            end
            default: res_taken = 1'b0;
        endcase
        res_next_pc  = res_taken ? res_target : res_link;
        res_misalign = res_taken & (res_target[1] | res_target[0]);
    end

    // Outputs return to their reset values whenever the block goes idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            taken_o    <= 1'b0;
            next_pc_o  <= RESET_PC;
            link_o     <= '0;
            misalign_o <= 1'b0;
        end else begin
            state <= state_next;
            if (accept && !(state == HOLD && flush_i)) begin
                taken_o    <= res_taken;
                next_pc_o  <= res_next_pc;
                link_o     <= res_link;
                misalign_o <= res_misalign;
            end else if (state_next == IDLE) begin
                taken_o    <= 1'b0;
                next_pc_o  <= RESET_PC;
                link_o     <= '0;
                misalign_o <= 1'b0;
            end
        end
    end

`ifdef BRANCH_RESOLVE_STAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches_o <= '0;
            stat_taken_o    <= '0;
            stat_jumps_o    <= '0;
        end else if (accept) begin
            if (op_i == OP_BR) begin
                stat_branches_o <= stat_branches_o + 32'd1;
                if (cmp_taken_i) begin
                    stat_taken_o <= stat_taken_o + 32'd1;
                end
            end
            if (op_i == OP_JAL || op_i == OP_JALR) begin
                stat_jumps_o <= stat_jumps_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - scoreboard bench for branch_resolve
// Directed cases followed by randomized traffic against a behavioural model.
module tb_branch_resolve;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op = 2'b00;
    logic        cmp = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] imm = '0;
    logic [31:0] rs1 = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        taken;
    logic [31:0] next_pc;
    logic [31:0] link;
    logic        misalign;
`ifdef BRANCH_RESOLVE_STAT_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_taken;
    logic [31:0] stat_jumps;
`endif

    always #5 clk = ~clk;

    branch_resolve #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .op_i(op), .cmp_taken_i(cmp), .pc_i(pc), .imm_i(imm), .rs1_i(rs1),
        .flush_i(flush),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .taken_o(taken), .next_pc_o(next_pc), .link_o(link), .misalign_o(misalign)
`ifdef BRANCH_RESOLVE_STAT_EN
        , .stat_branches_o(stat_branches), .stat_taken_o(stat_taken), .stat_jumps_o(stat_jumps)
`endif
    );

    typedef struct packed {
        logic        taken;
        logic [31:0] npc;
        logic [31:0] link;
        logic        mis;
    } res_t;

    res_t        q[$];
    int          total = 0;
    int          bad = 0;
    bit          started = 0;
    bit          m_valid = 0;
    bit          last_acc = 0;
    bit          acc;
    int unsigned m_br = 0, m_tk = 0, m_jp = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic res_t model(input logic [1:0] o, input logic c,
                                   input logic [31:0] p, input logic [31:0] im,
                                   input logic [31:0] r);
        res_t        x;
        logic [31:0] tgt;
        logic        t;
        case (o)
            2'd0:    begin t = c;    tgt = p + im; end
            2'd1:    begin t = 1'b1; tgt = p + im; end
            2'd2:    begin t = 1'b1; tgt = r + im; tgt = tgt - (tgt % 2); end
            default: begin t = 1'b0; tgt = 32'd0; end
        endcase
        x.taken = t;
        x.link  = p + 32'd4;
        x.npc   = t ? tgt : x.link;
        x.mis   = t && (tgt % 4 != 0);
        return x;
    endfunction

    // Tracks acceptance and pushes expected results at the clock edge.
    always @(posedge clk) begin
        last_acc = 0;
        if (rst) begin
            q.delete();
            m_valid = 0;
            m_br = 0; m_tk = 0; m_jp = 0;
        end else begin
            acc = in_valid && (!m_valid || (out_ready && !flush));
            if (m_valid && flush) begin
                if (q.size() > 0) void'(q.pop_front());
                m_valid = 0;
            end else if (acc) begin
                q.push_back(model(op, cmp, pc, imm, rs1));
                m_valid = 1;
                if (op == 2'd0) begin m_br++; if (cmp) m_tk++; end
                if (op == 2'd1 || op == 2'd2) m_jp++;
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
            last_acc = acc;
        end
    end

    // Monitor: compares whatever the DUT presents, pops on output handshake.
    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, !rst && (!m_valid || (out_ready && !flush))});
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            if (m_valid) begin
                if (q.size() == 0) begin
                    chk("queue_nonempty", 32'd0, 32'd1);
                end else begin
                    chk("taken", {31'd0, taken}, {31'd0, q[0].taken});
                    chk("next_pc", next_pc, q[0].npc);
                    chk("link", link, q[0].link);
                    chk("misalign", {31'd0, misalign}, {31'd0, q[0].mis});
                    if (out_ready && !flush && !rst) void'(q.pop_front());
                end
            end else begin
                chk("idle_next_pc", next_pc, RESET_PC);
            end
        end
    end

    task automatic send(input logic [1:0] o, input logic c, input logic [31:0] p,
                        input logic [31:0] im, input logic [31:0] r);
        bit ok = 0;
        in_valid = 1; op = o; cmp = c; pc = p; imm = im; rs1 = r;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk); #1;
            if (last_acc) ok = 1;
        end
        in_valid = 0;
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_out(input string name, input logic t, input logic [31:0] npc,
                              input logic [31:0] lnk, input logic mis);
        @(negedge clk);
        chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({name, "_taken"}, {31'd0, taken}, {31'd0, t});
        chk({name, "_npc"}, next_pc, npc);
        chk({name, "_link"}, link, lnk);
        chk({name, "_mis"}, {31'd0, misalign}, {31'd0, mis});
        @(posedge clk); #1;
    endtask

    initial begin
        @(posedge clk); #1;
        started = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_npc", next_pc, 32'h8000_0000);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        out_ready = 1;
        send(2'd0, 1'b1, 32'h8000_0010, 32'hFFFF_FFF8, 32'd0);
        expect_out("br_t", 1'b1, 32'h8000_0008, 32'h8000_0014, 1'b0);
        send(2'd0, 1'b0, 32'h8000_0010, 32'hFFFF_FFF8, 32'd0);
        expect_out("br_nt", 1'b0, 32'h8000_0014, 32'h8000_0014, 1'b0);
        send(2'd2, 1'b0, 32'h8000_0040, 32'd0, 32'h8000_1003);
        expect_out("jalr_mis", 1'b1, 32'h8000_1002, 32'h8000_0044, 1'b1);
        send(2'd2, 1'b0, 32'h8000_0040, 32'd0, 32'h8000_1001);
        expect_out("jalr_ok", 1'b1, 32'h8000_1000, 32'h8000_0044, 1'b0);

        // Stall with result held, then back-to-back handshakes.
        out_ready = 0;
        send(2'd0, 1'b1, 32'h8000_0200, 32'h0000_0010, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_npc", next_pc, 32'h8000_0210);
        end
        @(posedge clk); #1;
        out_ready = 1;
        send(2'd1, 1'b0, 32'h8000_0100, 32'h0000_0020, 32'd0);
        expect_out("jal_b2b", 1'b1, 32'h8000_0120, 32'h8000_0104, 1'b0);

        // Flush in HOLD with a competing bundle.
        out_ready = 0;
        send(2'd1, 1'b0, 32'h8000_0300, 32'h4, 32'd0);
        flush = 1; in_valid = 1; op = 2'd1; pc = 32'h8000_0400;
        @(posedge clk); #1;
        chk("flush_no_acc", {31'd0, last_acc}, 32'd0);
        flush = 0; in_valid = 0;
        @(negedge clk);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;

        // Reset while holding a result.
        send(2'd0, 1'b1, 32'h8000_0500, 32'h8, 32'd0);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("rst_hold_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_hold_npc", next_pc, RESET_PC);
        @(posedge clk); #1;

`ifdef BRANCH_RESOLVE_STAT_EN
        out_ready = 1;
        send(2'd0, 1'b1, 32'h8000_0000, 32'h10, 32'd0);
        send(2'd0, 1'b1, 32'h8000_0000, 32'h10, 32'd0);
        send(2'd0, 1'b0, 32'h8000_0000, 32'h10, 32'd0);
        send(2'd2, 1'b0, 32'h8000_0000, 32'h0, 32'h8000_2000);
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        @(negedge clk);
        chk("stat_branches", stat_branches, 32'd3);
        chk("stat_taken", stat_taken, 32'd2);
        chk("stat_jumps", stat_jumps, 32'd1);
        @(posedge clk); #1;
`endif

        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom % 100) == 0;
            flush     = m_valid && (($urandom % 16) == 0);
            in_valid  = ($urandom % 3) != 0;
            op        = 2'($urandom % 4);
            cmp       = 1'($urandom % 2);
            pc        = $urandom;
            imm       = (($urandom % 2) == 0) ? 32'($urandom % 64) - 32'd32 : $urandom;
            rs1       = $urandom;
            out_ready = ($urandom % 4) != 0;
            @(posedge clk); #1;
        end
        rst = 0; flush = 0; in_valid = 0; out_ready = 1;
        repeat (4) begin @(posedge clk); #1; end
        chk("drain_empty", q.size(), 32'd0);
`ifdef BRANCH_RESOLVE_STAT_EN
        @(negedge clk);
        chk("rnd_branches", stat_branches, m_br);
        chk("rnd_taken", stat_taken, m_tk);
        chk("rnd_jumps", stat_jumps, m_jp);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Consumes the single-bit condition from the compare unit, together with the instruction's PC, immediate and rs1 value.
- Resolves the next PC for conditional branches, JAL and JALR, and produces the link value.
- Registers the result and presents it to the fetch/writeback side over a valid/ready handshake.
- Sits directly downstream of the compare unit in the EXU and upstream of the IFU redirect path.

Parameters:
- XLEN, 32, datapath width of PC, immediate, rs1, target and link.
- RESET_PC, 32'h8000_0000, value driven on next_pc_o while in reset and idle.

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- in_valid_i  input  1  operand bundle valid
- in_ready_o  output  1  block can accept a bundle this cycle
- op_i  input  2  00 cond branch, 01 JAL, 10 JALR, 11 reserved
- cmp_taken_i  input  1  compare unit result for this bundle; used only when op_i=00
- pc_i  input  XLEN  PC of the instruction
- imm_i  input  XLEN  sign-extended immediate
- rs1_i  input  XLEN  rs1 value, JALR base
- flush_i  input  1  discard the held result
- out_valid_o  output  1  result valid
- out_ready_i  input  1  consumer accepts the result
- taken_o  output  1  redirect required
- next_pc_o  output  XLEN  resolved next PC
- link_o  output  XLEN  pc+4, the rd value for JAL/JALR
- misalign_o  output  1  taken target has target[1:0]!=0

Behaviour:
- States: IDLE, HOLD.
  - in_ready_o = (state==IDLE) | (out_valid_o & out_ready_i & ~flush_i).
  - Accept = in_valid_i & in_ready_o. All inputs, including cmp_taken_i, are sampled on the accept edge only.
- Resolution, computed combinationally from inputs and registered on accept:
  - op 00: taken=cmp_taken_i, target=pc_i+imm_i.
  - op 01: taken=1, target=pc_i+imm_i.
  - op 10: taken=1, target=(rs1_i+imm_i) & ~1.
  - op 11: taken=0; treated as non-branch.
  - next_pc = taken ? target : pc_i+4. link = pc_i+4.
  - All adds are modulo 2^XLEN; wrap-around is silent.
- misalign: taken & (target[1]|target[0]).
  - When set, next_pc_o still carries the target; trap handling is downstream.
  - For JALR, bit0 is cleared first, so only bit1 can flag.
- Latency: result is visible on out_valid_o the cycle after accept. Held stable until accepted.
- Transitions:
  - IDLE + accept -> HOLD.
  - HOLD + out_ready_i + no new accept -> IDLE.
  - HOLD + out_ready_i + accept -> HOLD, with the new result loaded the same edge (back-to-back, full throughput).
  - HOLD + ~out_ready_i -> HOLD; all outputs frozen.
- flush_i has priority over everything:
  - Next state IDLE, out_valid_o=0 next cycle.
  - No accept that cycle, since in_ready_o is forced low.
  - flush_i in IDLE is a no-op.
- Reset, applying mid-HOLD too:
  - Next edge: state IDLE, out_valid_o=0, taken_o=0, misalign_o=0, next_pc_o=RESET_PC, link_o=0.
  - Any held result is discarded.
- in_ready_o is low during the cycle rst is high.

Optional Feature:
- Macro BRANCH_RESOLVE_STAT_EN.
- Defined: adds outputs stat_branches_o (32), stat_taken_o (32) and stat_jumps_o (32).
  - stat_branches_o increments on each accepted op 00.
  - stat_taken_o increments on each accepted op 00 with cmp_taken_i=1.
  - stat_jumps_o increments on each accepted op 01/10.
  - Counters are cleared by rst, not by flush_i, and wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, then idle -> out_valid_o=0, next_pc_o=32'h8000_0000, in_ready_o=1.
- op=00, pc=0x80000010, imm=0xFFFFFFF8, cmp_taken=1, out_ready=1 -> one cycle later out_valid=1, taken=1, next_pc=0x80000008, link=0x80000014. Repeat with cmp_taken=0 -> taken=0, next_pc=0x80000014.
- op=10, rs1=0x80001003, imm=0 -> next_pc=0x80001002, misalign_o=1. Repeat with rs1=0x80001001 -> next_pc=0x80001000, misalign_o=0.
- out_ready_i=0 for 3 cycles after result -> outputs stable, in_ready_o=0. Assert out_ready_i with a new JAL (pc=0x80000100, imm=0x20) valid -> both handshakes fire on the same edge, next_pc=0x80000120.
- flush_i in HOLD together with in_valid_i=1 -> next cycle out_valid_o=0, bundle not accepted. rst asserted in HOLD -> out_valid_o=0 next cycle.
- With BRANCH_RESOLVE_STAT_EN: 2 taken branches, 1 not-taken branch, 1 JALR -> stat_branches=3, stat_taken=2, stat_jumps=1; a flush leaves the counters unchanged.
